instr_encoder_loader: RTL and testbench

// - Inverse of the MIPS control decoder: builds 32-bit MIPS instruction words from field tuples and streams them into instruction memory.
// - Sits between the boot/debug program source and the imem write port; loads programs before the core leaves reset.
// - Supports exactly the ISA subset the core decodes. Registered encode stage feeds a 2-entry output FIFO.

---
 rtl/instr_encoder_loader_pkg.sv | 96 +++++++++
 rtl/instr_fifo2.sv | 66 ++++++
 rtl/instr_encoder_loader.sv | 139 +++++++++++++
 tb/tb_instr_encoder_loader.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_encoder_loader_pkg.sv
// Shared MIPS ISA definitions for the instruction encoder/loader.
// Holds the instruction-kind enumeration presented on in_kind, the opcode
// and function-code constants (kept bit-identical to the core's decoder),
// the loader FSM state type and the field-tuple encoder.
package instr_encoder_loader_pkg;

  // Instruction kinds accepted on in_kind; anything above KIND_JAL is illegal.
  typedef enum logic [4:0] {
    KIND_ADDU  = 5'd0,
    KIND_SUBU  = 5'd1,
    KIND_AND   = 5'd2,
    KIND_OR    = 5'd3,
    KIND_SLTU  = 5'd4,
    KIND_MULTU = 5'd5,
    KIND_MFHI  = 5'd6,
    KIND_MFLO  = 5'd7,
    KIND_LW    = 5'd8,
    KIND_SW    = 5'd9,
    KIND_BEQ   = 5'd10,
    KIND_ADDIU = 5'd11,
    KIND_ORI   = 5'd12,
    KIND_LUI   = 5'd13,
    KIND_BLTZ  = 5'd14,
    KIND_J     = 5'd15,
    KIND_JAL   = 5'd16
  } kind_e;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_ADDIU   = 6'b001001;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_SW      = 6'b101011;

  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_ADDU  = 6'b100001;
  localparam logic [5:0] FUNCT_SUBU  = 6'b100011;
  localparam logic [5:0] FUNCT_AND   = 6'b100100;
  localparam logic [5:0] FUNCT_OR    = 6'b100101;
  localparam logic [5:0] FUNCT_SLTU  = 6'b101011;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic        legal;
    logic [31:0] word;
  } enc_t;

  // Builds the instruction word for one field tuple. shamt and every field
  // the instruction does not use are forced to zero.
  function automatic enc_t encode(
    input logic [4:0]  kind,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [15:0] imm,
    input logic [25:0] target
  );
    enc_t r;
    r.legal = 1'b1;
    r.word  = '0;
    case (kind)
      KIND_ADDU:  r.word = {OP_SPECIAL, rs, rt, rd, 5'd0, FUNCT_ADDU};
      KIND_SUBU:  r.word = {OP_SPECIAL, rs, rt, rd, 5'd0, FUNCT_SUBU};
      KIND_AND:   r.word = {OP_SPECIAL, rs, rt, rd, 5'd0, FUNCT_AND};
      KIND_OR:    r.word = {OP_SPECIAL, rs, rt, rd, 5'd0, FUNCT_OR};
      KIND_SLTU:  r.word = {OP_SPECIAL, rs, rt, rd, 5'd0, FUNCT_SLTU};
      KIND_MULTU: r.word = {OP_SPECIAL, rs, rt, 5'd0, 5'd0, FUNCT_MULTU};
      KIND_MFHI:  r.word = {OP_SPECIAL, 5'd0, 5'd0, rd, 5'd0, FUNCT_MFHI};
      KIND_MFLO:  r.word = {OP_SPECIAL, 5'd0, 5'd0, rd, 5'd0, FUNCT_MFLO};
      KIND_LW:    r.word = {OP_LW, rs, rt, imm};
      KIND_SW:    r.word = {OP_SW, rs, rt, imm};
      KIND_BEQ:   r.word = {OP_BEQ, rs, rt, imm};
      KIND_ADDIU: r.word = {OP_ADDIU, rs, rt, imm};
      KIND_ORI:   r.word = {OP_ORI, rs, rt, imm};
      KIND_LUI:   r.word = {OP_LUI, 5'd0, rt, imm};
      KIND_BLTZ:  r.word = {OP_REGIMM, rs, 5'd0, imm};
      KIND_J:     r.word = {OP_J, target};
      KIND_JAL:   r.word = {OP_JAL, target};
      default:    r.legal = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/instr_fifo2.sv
// Two-entry FIFO holding {address, instruction} imem write requests.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   flush_i          drop all entries (wins over push/pop)
//   push_i, data_i   enqueue; ignored when full unless a pop frees a slot
//   pop_i            dequeue head; ignored when empty
//   data_o           head entry (entry 0), held stable until popped
//   count_o          occupancy 0..2
module instr_fifo2 #(
  parameter int unsigned W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] e0_q;
  logic [W-1:0] e1_q;
  logic [1:0]   cnt_q;
  logic         do_pop;
  logic         do_push;

  assign do_pop  = pop_i && (cnt_q != 2'd0);
  assign do_push = push_i && ((cnt_q < 2'd2) || do_pop);

  // Entry 0 is always the head, so data_o comes straight from a register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      cnt_q <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (cnt_q == 2'd0) e0_q <= data_i;
          else               e1_q <= data_i;
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          e0_q  <= e1_q;
          cnt_q <= cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            e0_q <= data_i;
          end else begin
            e0_q <= e1_q;
            e1_q <= data_i;
          end
        end
        default: ;
      endcase
    end
  end

  assign data_o  = e0_q;
  assign count_o = cnt_q;

endmodule

// File: rtl/instr_encoder_loader.sv
// MIPS instruction encoder / imem loader.
// Turns field tuples into 32-bit MIPS words and streams them, with
// sequential byte addresses from BASE_ADDR, into the imem write port.
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   start, finish              begin program at BASE_ADDR / stop and drain
//   in_valid/in_ready          tuple handshake; in_kind, in_rs, in_rt,
//                              in_rd, in_imm, in_target carry the fields
//   out_valid/out_ready        imem write handshake; out_addr, out_instr
//   words                      legal words accepted since start
//   illegal                    sticky: an undefined kind was accepted
//   done                       one-cycle pulse when draining completes
module instr_encoder_loader
  import instr_encoder_loader_pkg::*;
#(
  parameter int unsigned        ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
  parameter int unsigned        MAX_WORDS = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_instr,
  output logic [6:0]        words,
  output logic              illegal,
  output logic              done
);

  localparam int unsigned FW    = ADDR_W + 32;
  localparam logic [6:0]  MAX_W = 7'(MAX_WORDS);

  state_e            state_q;
  logic [6:0]        words_q;
  logic              illegal_q;
  logic              done_q;
  logic              enc_valid_q;
  logic [ADDR_W-1:0] enc_addr_q;
  logic [31:0]       enc_instr_q;

  enc_t              enc_d;
  logic [ADDR_W-1:0] addr_d;
  logic              accept;
  logic              push;
  logic              pop;
  logic [1:0]        fifo_count;
  logic [FW-1:0]     fifo_head;

  always_comb begin
    enc_d  = encode(in_kind, in_rs, in_rt, in_rd, in_imm, in_target);
    addr_d = BASE_ADDR + (ADDR_W'(words_q) << 2);
  end

  assign in_ready = (state_q == ST_RUN) && (fifo_count < 2'd2) && (words_q < MAX_W);
  // start takes priority over any handshake in the same cycle.
  assign accept   = in_valid && in_ready && !start;
  assign pop      = out_valid && out_ready;
  // The encode register may advance into a full FIFO when its head leaves.
  assign push     = enc_valid_q && ((fifo_count < 2'd2) || pop);

  instr_fifo2 #(
    .W(FW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .flush_i (start),
    .push_i  (push),
    .data_i  ({enc_addr_q, enc_instr_q}),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .count_o (fifo_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      words_q     <= '0;
      illegal_q   <= 1'b0;
      done_q      <= 1'b0;
      enc_valid_q <= 1'b0;
      enc_addr_q  <= '0;
      enc_instr_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        state_q     <= ST_RUN;
        words_q     <= '0;
        illegal_q   <= 1'b0;
        enc_valid_q <= 1'b0;
      end else begin
        // A same-cycle reload overrides the clear caused by the push.
        if (push) enc_valid_q <= 1'b0;
        if (accept) begin
          if (enc_d.legal) begin
            enc_valid_q <= 1'b1;
            enc_addr_q  <= addr_d;
            enc_instr_q <= enc_d.word;
            words_q     <= words_q + 7'd1;
          end else begin
            illegal_q <= 1'b1;
          end
        end
        case (state_q)
          ST_IDLE: ;
          ST_RUN: begin
            if (finish || (words_q == MAX_W)) state_q <= ST_DRAIN;
          end
          ST_DRAIN: begin
            if ((fifo_count == 2'd0) && !enc_valid_q) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end
          ST_DONE: state_q <= ST_IDLE;
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign out_valid = (fifo_count != 2'd0);
  assign out_addr  = fifo_head[FW-1:32];
  assign out_instr = fifo_head[31:0];
  assign words     = words_q;
  assign illegal   = illegal_q;
  assign done      = done_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
module tb_instr_encoder_loader;
  import instr_encoder_loader_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        finish;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_kind;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_addr;
  logic [31:0] out_instr;
  logic [6:0]  words;
  logic        illegal;
  logic        done;

  int unsigned total = 0;
  int unsigned bad   = 0;

  int unsigned wr_cnt = 0;
  logic [31:0] last_addr  = '0;
  logic [31:0] last_instr = '0;

  always #5 clk = ~clk;

  instr_encoder_loader #(
    .ADDR_W    (32),
    .BASE_ADDR (32'h0),
    .MAX_WORDS (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .finish    (finish),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_kind   (in_kind),
    .in_rs     (in_rs),
    .in_rt     (in_rt),
    .in_rd     (in_rd),
    .in_imm    (in_imm),
    .in_target (in_target),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .out_instr (out_instr),
    .words     (words),
    .illegal   (illegal),
    .done      (done)
  );

  // imem-side write log, sampled mid-cycle
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      wr_cnt++;
      last_addr  = out_addr;
      last_instr = out_instr;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] k, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt);
    in_valid  = 1'b1;
    in_kind   = k;
    in_rs     = rs;
    in_rt     = rt;
    in_rd     = rd;
    in_imm    = imm;
    in_target = tgt;
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    int unsigned base;
    logic seen;

    reset = 1'b0; start = 1'b0; finish = 1'b0; in_valid = 1'b0;
    in_kind = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0; in_target = '0;
    out_ready = 1'b0;

    // reset state
    step(); step();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_addr", out_addr, 0);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_words", words, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_done", done, 0);
    reset = 1'b1;
    step();
    chk("idle_in_ready", in_ready, 0);

    // single ADDU, one-cycle latency
    out_ready = 1'b1;
    do_start();
    chk("run_in_ready", in_ready, 1);
    drive(KIND_ADDU, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    step();
    idle_in();
    chk("addu_encreg_no_out", out_valid, 0);
    chk("addu_words", words, 1);
    step();
    chk("addu_valid", out_valid, 1);
    chk("addu_instr", out_instr, 32'h00221821);
    chk("addu_addr", out_addr, 32'h0);
    step();
    chk("addu_popped", out_valid, 0);

    // LUI / ORI / JAL back-to-back, then finish -> done two cycles later
    do_start();
    drive(KIND_LUI, 5'd0, 5'd8, 5'd0, 16'h1234, 26'h0);
    step();
    drive(KIND_ORI, 5'd8, 5'd8, 5'd0, 16'h5678, 26'h0);
    step();
    chk("lui_instr", out_instr, 32'h3C081234);
    chk("lui_addr", out_addr, 32'h0);
    drive(KIND_JAL, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10);
    step();
    chk("ori_instr", out_instr, 32'h35085678);
    chk("ori_addr", out_addr, 32'h4);
    idle_in();
    step();
    chk("jal_instr", out_instr, 32'h0C000010);
    chk("jal_addr", out_addr, 32'h8);
    step();
    chk("seq_empty", out_valid, 0);
    chk("seq_words", words, 3);
    finish = 1'b1;
    step();
    finish = 1'b0;
    chk("fin_done_early", done, 0);
    step();
    chk("fin_done", done, 1);
    step();
    chk("fin_done_pulse", done, 0);
    chk("fin_idle_in_ready", in_ready, 0);

    // field forcing: MULTU rd=0, MFLO rs=rt=0, BLTZ rt=0, LW
    do_start();
    drive(KIND_MULTU, 5'd3, 5'd4, 5'd5, 16'h0, 26'h0);
    step();
    drive(KIND_MFLO, 5'd7, 5'd8, 5'd6, 16'h0, 26'h0);
    step();
    chk("multu_instr", out_instr, 32'h00640019);
    drive(KIND_BLTZ, 5'd9, 5'd10, 5'd0, 16'hFFFE, 26'h0);
    step();
    chk("mflo_instr", out_instr, 32'h00003012);
    drive(KIND_LW, 5'd29, 5'd2, 5'd0, 16'h0008, 26'h0);
    step();
    chk("bltz_instr", out_instr, 32'h0520FFFE);
    chk("bltz_addr", out_addr, 32'h8);
    idle_in();
    step();
    chk("lw_instr", out_instr, 32'h8FA20008);
    chk("lw_addr", out_addr, 32'hC);
    chk("lw_words", words, 4);

    // backpressure: out_ready low for 5 cycles with a continuous source
    out_ready = 1'b0;
    do_start();
    drive(KIND_ADDU, 5'd2, 5'd3, 5'd1, 16'h0, 26'h0);
    step();
    drive(KIND_SUBU, 5'd5, 5'd6, 5'd4, 16'h0, 26'h0);
    step();
    drive(KIND_AND, 5'd8, 5'd9, 5'd7, 16'h0, 26'h0);
    step();
    drive(KIND_OR, 5'd11, 5'd12, 5'd10, 16'h0, 26'h0);
    chk("stall_in_ready_full", in_ready, 0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("stall_head_stable", out_instr, 32'h00430821);
    end
    chk("stall_in_ready", in_ready, 0);
    chk("stall_valid", out_valid, 1);
    chk("stall_addr", out_addr, 32'h0);
    chk("stall_words", words, 3);
    out_ready = 1'b1;
    step();
    chk("rel_t1_instr", out_instr, 32'h00A62023);
    chk("rel_t1_addr", out_addr, 32'h4);
    step();
    chk("rel_t2_instr", out_instr, 32'h01093824);
    chk("rel_t2_addr", out_addr, 32'h8);
    chk("rel_in_ready", in_ready, 1);
    step();
    idle_in();
    chk("rel_gap", out_valid, 0);
    step();
    chk("rel_t3_instr", out_instr, 32'h016C5025);
    chk("rel_t3_addr", out_addr, 32'hC);
    chk("rel_words", words, 4);

    // word cap: 6 BEQ offered, only 4 written
    do_start();
    base = wr_cnt;
    for (int i = 0; i < 6; i++) begin
      drive(KIND_BEQ, 5'd1, 5'd2, 5'd0, 16'(i), 26'h0);
      step();
    end
    chk("cap_in_ready", in_ready, 0);
    idle_in();
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (done) seen = 1'b1;
      else step();
    end
    chk("cap_done", seen, 1);
    chk("cap_writes", 64'(wr_cnt - base), 4);
    chk("cap_last_addr", last_addr, 32'hC);
    chk("cap_last_instr", last_instr, 32'h10220003);
    chk("cap_words", words, 4);

    // illegal kind mid-stream
    do_start();
    drive(KIND_ADDU, 5'd2, 5'd3, 5'd1, 16'h0, 26'h0);
    step();
    drive(5'd31, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0);
    step();
    chk("ill_pre_instr", out_instr, 32'h00430821);
    drive(KIND_SUBU, 5'd5, 5'd6, 5'd4, 16'h0, 26'h0);
    step();
    idle_in();
    chk("ill_no_write", out_valid, 0);
    chk("ill_flag", illegal, 1);
    step();
    chk("ill_next_instr", out_instr, 32'h00A62023);
    chk("ill_next_addr", out_addr, 32'h4);
    chk("ill_words", words, 2);
    do_start();
    chk("ill_cleared", illegal, 0);
    chk("ill_words_cleared", words, 0);

    // asynchronous reset while a write is stalled
    out_ready = 1'b0;
    drive(KIND_ORI, 5'd1, 5'd2, 5'd0, 16'hBEEF, 26'h0);
    step();
    idle_in();
    step();
    chk("ar_pre_valid", out_valid, 1);
    base = wr_cnt;
    reset = 1'b0;
    #1;
    chk("ar_valid_drop", out_valid, 0);
    step();
    out_ready = 1'b1;
    step();
    reset = 1'b1;
    step();
    chk("ar_words", words, 0);
    chk("ar_idle", in_ready, 0);
    chk("ar_out_valid", out_valid, 0);
    chk("ar_no_write", 64'(wr_cnt - base), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
